// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx : 8N1 serial receiver with valid/ack holding register.
//
// Oversamples the idle-high serial line at CLKS_PER_BIT clocks per bit,
// re-centres on the start bit and captures 8 data bits LSB first plus the
// stop bit. The received byte is held in a holding register until the
// consumer acknowledges it. Framing errors and overruns are reported
// through sticky flags.
//
// Ports
//   clk       : rising-edge clock for all logic
//   reset     : synchronous active-low reset
//   pin       : serial line, idle high, asynchronous to clk
//   rx_en     : 1 = new start bits may be detected; 0 aborts a frame
//   ack       : consumer accepts data, clears valid
//   clr_err   : clears frame_err and overrun
//   data      : last received byte
//   valid     : data holds an unread byte
//   frame_err : sticky, stop bit sampled low
//   overrun   : sticky, byte completed while an unread byte was held
//   busy      : receiver is not idle
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | line idle, waiting for rxs=0 while rx_en=1
// S_START   | timing to mid start bit to reject glitches
// S_DATA    | sampling 8 data bits at mid-bit
// S_STOP    | sampling the stop bit, loading the holding register
// S_WAIT_HIGH | after a framing error, wait for the line to return high
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pin,
   input  logic       rx_en,
   input  logic       ack,
   input  logic       clr_err,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t          r_state;
   logic            r_sync1;
   logic            r_sync2;
   logic [CW-1:0]   r_clk_cnt;
   logic [3:0]      r_bit_idx;
   logic [7:0]      r_shift;
   logic [7:0]      r_data;
   logic            r_valid;
   logic            r_frame_err;
   logic            r_overrun;
   logic            w_rxs;

   assign w_rxs = r_sync2;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_clk_cnt   <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_data      <= 8'h00;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_sync1 <= pin;
         r_sync2 <= r_sync1;

         // Clears first; any load or flag set below overrides them.
         if (ack)
            r_valid <= 1'b0;
         if (clr_err) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (rx_en && !w_rxs) begin
                  r_state   <= S_START;
                  r_clk_cnt <= '0;
               end
            end

            S_START: begin
               if (!rx_en) begin
                  r_state <= S_IDLE;
               end else if (r_clk_cnt == HALF_TC) begin
                  if (!w_rxs) begin
                     r_state   <= S_DATA;
                     r_clk_cnt <= '0;
                     r_bit_idx <= '0;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CW'(1);
               end
            end

            S_DATA: begin
               if (!rx_en) begin
                  r_state <= S_IDLE;
               end else if (r_clk_cnt == FULL_TC) begin
                  r_shift[r_bit_idx[2:0]] <= w_rxs;
                  r_clk_cnt <= '0;
                  if (r_bit_idx != 4'd8)
                     r_bit_idx <= r_bit_idx + 4'd1;
                  if (r_bit_idx == 4'd7)
                     r_state <= S_STOP;
               end else begin
                  r_clk_cnt <= r_clk_cnt + CW'(1);
               end
            end

            S_STOP: begin
               if (!rx_en) begin
                  r_state <= S_IDLE;
               end else if (r_clk_cnt == FULL_TC) begin
                  if (w_rxs) begin
                     // An ack in the same cycle frees the holding register.
                     if (!r_valid || ack) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                     end else begin
                        r_overrun <= 1'b1;
                     end
                     r_state <= S_IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= S_WAIT_HIGH;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CW'(1);
               end
            end

            S_WAIT_HIGH: begin
               // A held-low line (break) must not look like a new start bit.
               if (w_rxs)
                  r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data      = r_data;
   assign valid     = r_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = (r_state != S_IDLE);

endmodule
